multicycle_control: RTL and testbench

- Parametrised successor of the single-cycle main decoder: an FSM controller for the multicycle RV32 datapath (lw, sw, R-type, I-type ALU, branch, jal).
- Sequences each instruction over 3-5 cycles, sharing one ALU and one memory port.
- Adds handshaked memory with an optional timeout, optional bne support, and an illegal-opcode trap in place of the old default-to-J-type.

---
 rtl/multicycle_control_if.sv | 10 +
 rtl/multicycle_control.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between the multicycle controller and the shared memory port.
// The controller drives the request and write strobe; memory answers with ready.
interface multicycle_control_if;
    logic mem_req;
    logic mem_write;
    logic mem_ready;

    modport master (output mem_req, output mem_write, input mem_ready);
    modport slave  (input mem_req, input mem_write, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// FSM controller for the multicycle RV32 datapath: one ALU and one memory port shared
// across 3-5 cycle instruction sequences, with memory handshake, timeout and illegal traps.
module multicycle_control #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int WAIT_LIMIT    = 0,
    parameter bit BRANCH_EXT    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master mem,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           inm_src,
    output logic [1:0]           result_src,
    output logic [2:0]           type_md,
    output logic [3:0]           state_o,
    output logic                 illegal,
    output logic                 mem_err
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // A zero-width counter is not legal, so the no-timeout build keeps one idle bit.
    localparam int            CW       = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] wait_cnt, wait_cnt_n;
    logic          rdy, stall, timeout;
    logic          br_legal, br_take;
    logic          set_ill, set_err;
    logic          req_c, wr_c, irw_c, pcw_c, rgw_c;

    assign rdy      = MEM_HANDSHAKE ? mem.mem_ready : 1'b1;
    assign stall    = (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE) && !rdy;
    // Ready in the last allowed cycle still wins: timeout needs ready low right now.
    assign timeout  = (WAIT_LIMIT > 0) && stall && (wait_cnt == CNT_LAST);
    assign br_legal = (funct3 == 3'b000) || (BRANCH_EXT && funct3 == 3'b001);
    assign br_take  = (funct3 == 3'b001) ? !zero : zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            illegal  <= illegal | set_ill;
            mem_err  <= mem_err | set_err;
        end
    end

    always_comb begin
        state_n    = state;
        set_ill    = 1'b0;
        set_err    = 1'b0;
        req_c      = 1'b0;
        wr_c       = 1'b0;
        irw_c      = 1'b0;
        pcw_c      = 1'b0;
        rgw_c      = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        inm_src    = 2'b00;
        result_src = 2'b00;
        case (state)
            S_FETCH: begin
                req_c      = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                irw_c      = rdy;
                pcw_c      = rdy;
                if (rdy) begin
                    state_n = S_DECODE;
                end else if (timeout) begin
                    state_n = S_TRAP;
                    set_err = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                inm_src   = 2'b10;
                case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = S_EXECR;
                    OP_I:         state_n = S_EXECI;
                    OP_JAL:       state_n = S_JAL;
                    OP_B: begin
                        state_n = br_legal ? S_BRANCH : S_TRAP;
                        set_ill = !br_legal;
                    end
                    default: begin
                        state_n = S_TRAP;
                        set_ill = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                inm_src   = (op == OP_SW) ? 2'b01 : 2'b00;
                state_n   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                req_c   = 1'b1;
                adr_src = 1'b1;
                if (rdy) begin
                    state_n = S_MEMWB;
                end else if (timeout) begin
                    state_n = S_TRAP;
                    set_err = 1'b1;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                rgw_c      = 1'b1;
                state_n    = S_FETCH;
            end
            S_MEMWRITE: begin
                req_c   = 1'b1;
                wr_c    = 1'b1;
                adr_src = 1'b1;
                if (rdy) begin
                    state_n = S_FETCH;
                end else if (timeout) begin
                    state_n = S_TRAP;
                    set_err = 1'b1;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_n   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_n   = S_ALUWB;
            end
            S_ALUWB: begin
                rgw_c   = 1'b1;
                state_n = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pcw_c     = br_take;
                state_n   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                inm_src   = 2'b11;
                pcw_c     = 1'b1;
                state_n   = S_ALUWB;
            end
            default: state_n = S_TRAP;
        endcase
    end

    always_comb begin
        wait_cnt_n = '0;
        if (WAIT_LIMIT > 0 && stall && state_n == state)
            wait_cnt_n = wait_cnt + 1'b1;
    end

    always_comb begin
        case (op)
            OP_LW, OP_I: type_md = 3'b000;
            OP_SW:       type_md = 3'b001;
            OP_R:        type_md = 3'b010;
            OP_B:        type_md = 3'b011;
            OP_JAL:      type_md = 3'b100;
            default:     type_md = 3'b111;
        endcase
    end

    // State resets asynchronously to FETCH, but FETCH itself requests memory, so
    // the enables are masked with reset directly to keep them low for the whole pulse.
    assign mem.mem_req   = req_c & ~reset;
    assign mem.mem_write = wr_c  & ~reset;
    assign ir_write      = irw_c & ~reset;
    assign pc_write      = pcw_c & ~reset;
    assign reg_write     = rgw_c & ~reset;
    assign state_o       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench: instruction-level reference model queues expected per-cycle
// outputs; a negedge monitor pops and compares. dut_a: WAIT_LIMIT=4, dut_b: WAIT_LIMIT=0, no bne.
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

    typedef struct packed {
        logic [3:0] st;
        logic       mreq, mwr, irw, pcw, rgw, adr;
        logic [1:0] sa, sb, aop, imm, res;
        logic [2:0] typ;
        logic       ill, merr;
    } rec_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  [2] = '{1'b1, 1'b1};
    logic       rdy  [2] = '{1'b0, 1'b0};
    logic [6:0] op   [2] = '{7'd0, 7'd0};
    logic [2:0] f3   [2] = '{3'd0, 3'd0};
    logic       zero [2] = '{1'b0, 1'b0};
    bit         e_ill[2] = '{1'b0, 1'b0};
    bit         e_err[2] = '{1'b0, 1'b0};

    rec_t q0[$], q1[$];
    int   n_cmp = 0, n_bad = 0;

    multicycle_control_if bus_a ();
    multicycle_control_if bus_b ();
    assign bus_a.mem_ready = rdy[0];
    assign bus_b.mem_ready = rdy[1];

    logic       adr_a, irw_a, pcw_a, rgw_a, ill_a, err_a;
    logic [1:0] sa_a, sb_a, aop_a, imm_a, res_a;
    logic [2:0] typ_a;
    logic [3:0] st_a;
    logic       adr_b, irw_b, pcw_b, rgw_b, ill_b, err_b;
    logic [1:0] sa_b, sb_b, aop_b, imm_b, res_b;
    logic [2:0] typ_b;
    logic [3:0] st_b;

    multicycle_control #(.MEM_HANDSHAKE(1'b1), .WAIT_LIMIT(4), .BRANCH_EXT(1'b1)) dut_a (
        .clk(clk), .reset(rst[0]), .mem(bus_a.master), .op(op[0]), .funct3(f3[0]), .zero(zero[0]),
        .adr_src(adr_a), .ir_write(irw_a), .pc_write(pcw_a), .reg_write(rgw_a),
        .alu_src_a(sa_a), .alu_src_b(sb_a), .alu_op(aop_a), .inm_src(imm_a), .result_src(res_a),
        .type_md(typ_a), .state_o(st_a), .illegal(ill_a), .mem_err(err_a));

    multicycle_control #(.MEM_HANDSHAKE(1'b1), .WAIT_LIMIT(0), .BRANCH_EXT(1'b0)) dut_b (
        .clk(clk), .reset(rst[1]), .mem(bus_b.master), .op(op[1]), .funct3(f3[1]), .zero(zero[1]),
        .adr_src(adr_b), .ir_write(irw_b), .pc_write(pcw_b), .reg_write(rgw_b),
        .alu_src_a(sa_b), .alu_src_b(sb_b), .alu_op(aop_b), .inm_src(imm_b), .result_src(res_b),
        .type_md(typ_b), .state_o(st_b), .illegal(ill_b), .mem_err(err_b));

    function automatic rec_t act(input int d);
        if (d == 0)
            return '{st_a, bus_a.mem_req, bus_a.mem_write, irw_a, pcw_a, rgw_a, adr_a,
                     sa_a, sb_a, aop_a, imm_a, res_a, typ_a, ill_a, err_a};
        return '{st_b, bus_b.mem_req, bus_b.mem_write, irw_b, pcw_b, rgw_b, adr_b,
                 sa_b, sb_b, aop_b, imm_b, res_b, typ_b, ill_b, err_b};
    endfunction

    function automatic logic [2:0] typ_of(input logic [6:0] o);
        if (o == LW || o == IT) return 3'b000;
        if (o == SW) return 3'b001;
        if (o == RT) return 3'b010;
        if (o == BR) return 3'b011;
        if (o == JL) return 3'b100;
        return 3'b111;
    endfunction

    // Expected outputs for one cycle spent in state st, straight from the control table.
    function automatic rec_t exp_rec(input int d, input logic [3:0] st, input bit r);
        rec_t e = '0;
        e.st = st; e.typ = typ_of(op[d]); e.ill = e_ill[d]; e.merr = e_err[d];
        case (st)
            4'd0:  begin e.mreq = 1; e.irw = r; e.pcw = r; e.sb = 2'b10; e.res = 2'b10; end
            4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; e.imm = 2'b10; end
            4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; e.imm = (op[d] == SW) ? 2'b01 : 2'b00; end
            4'd3:  begin e.mreq = 1; e.adr = 1; end
            4'd4:  begin e.res = 2'b01; e.rgw = 1; end
            4'd5:  begin e.mreq = 1; e.mwr = 1; e.adr = 1; end
            4'd6:  begin e.sa = 2'b10; e.aop = 2'b10; end
            4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
            4'd8:  e.rgw = 1;
            4'd9:  begin e.sa = 2'b10; e.aop = 2'b01; e.pcw = (f3[d] == 3'b000) ? zero[d] : !zero[d]; end
            4'd10: begin e.sa = 2'b01; e.sb = 2'b10; e.imm = 2'b11; e.pcw = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input int d, input rec_t e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic cyc(input int d, input logic [3:0] st, input bit r);
        rdy[d] = r;
        push(d, exp_rec(d, st, r));
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int d);
        rec_t e;
        rst[d] = 1'b1; e_ill[d] = 0; e_err[d] = 0;
        e = exp_rec(d, 4'd0, 1'b0);
        e.mreq = 1'b0;
        push(d, e);
        @(posedge clk); #1;
        rst[d] = 1'b0;
    endtask

    task automatic trap(input int d, input bit is_ill, input int n);
        if (is_ill) e_ill[d] = 1; else e_err[d] = 1;
        for (int i = 0; i < n; i++) cyc(d, 4'd11, rb());
    endtask

    // Memory state with `stalls` ready-low cycles then ready; dut_a gives up after 4 stalls.
    task automatic mem_state(input int d, input logic [3:0] st, input int stalls, output bit tr);
        int wl = (d == 0) ? 4 : 0;
        tr = 0;
        for (int k = 0; k <= stalls; k++) begin
            cyc(d, st, k == stalls);
            if (k < stalls && wl > 0 && k == wl - 1) begin tr = 1; return; end
        end
    endtask

    task automatic issue(input int d, input logic [6:0] o, input logic [2:0] f, input bit z,
                         input int fs, input int ms, input int tn, output bit tr);
        bit legal_br = (f == 3'b000) || (d == 0 && f == 3'b001);
        op[d] = o; f3[d] = f; zero[d] = z; tr = 0;
        mem_state(d, 4'd0, fs, tr);
        if (tr) begin trap(d, 0, tn); return; end
        cyc(d, 4'd1, rb());
        if (o == LW) begin
            cyc(d, 4'd2, rb()); mem_state(d, 4'd3, ms, tr);
            if (tr) trap(d, 0, tn); else cyc(d, 4'd4, rb());
        end else if (o == SW) begin
            cyc(d, 4'd2, rb()); mem_state(d, 4'd5, ms, tr);
            if (tr) trap(d, 0, tn);
        end else if (o == RT) begin
            cyc(d, 4'd6, rb()); cyc(d, 4'd8, rb());
        end else if (o == IT) begin
            cyc(d, 4'd7, rb()); cyc(d, 4'd8, rb());
        end else if (o == JL) begin
            cyc(d, 4'd10, rb()); cyc(d, 4'd8, rb());
        end else if (o == BR && legal_br) begin
            cyc(d, 4'd9, rb());
        end else begin
            tr = 1; trap(d, 1, tn);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, a, e);
        end
    endtask

    task automatic check(input int d, input rec_t e);
        rec_t a = act(d);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL dut%0d cycle @%0t: actual st=%0d rec=%h, required st=%0d rec=%h",
                     d, $time, a.st, a, e.st, e);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) check(0, q0.pop_front());
        if (q1.size() > 0) check(1, q1.pop_front());
    end

    task automatic random_run(input int d, input int n);
        logic [6:0] o;
        bit tr;
        int fs, ms;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 7))
                0: o = LW; 1: o = SW; 2: o = RT; 3: o = IT; 4, 5: o = BR; 6: o = JL;
                default: begin
                    o = 7'($urandom);
                    if (o inside {LW, SW, RT, IT, BR, JL}) o = 7'b0000000;
                end
            endcase
            fs = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            ms = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            issue(d, o, 3'($urandom_range(0, 2)), rb(), fs, ms, 3, tr);
            if (tr) do_reset(d);
        end
    endtask

    initial begin
        bit tr;
        @(posedge clk); #1;
        do_reset(0);
        // ready always high: lw/sw/add/addi/jal, then beq taken/not taken, bne taken
        issue(0, LW, 3'd2, 0, 0, 0, 3, tr);
        issue(0, SW, 3'd2, 0, 0, 0, 3, tr);
        issue(0, RT, 3'd0, 0, 0, 0, 3, tr);
        issue(0, IT, 3'd0, 1, 0, 0, 3, tr);
        issue(0, JL, 3'd0, 0, 0, 0, 3, tr);
        issue(0, BR, 3'd0, 1, 0, 0, 3, tr);
        issue(0, BR, 3'd0, 0, 0, 0, 3, tr);
        issue(0, BR, 3'd1, 0, 0, 0, 3, tr);
        issue(0, BR, 3'd1, 1, 0, 0, 3, tr);
        // illegal opcode: trap held for 20 cycles, then reset clears it
        issue(0, 7'b0000000, 3'd0, 0, 0, 0, 20, tr);
        do_reset(0);
        // fetch timeout after 4 stalls, and ready arriving in the 4th cycle
        issue(0, RT, 3'd0, 0, 4, 0, 4, tr);
        do_reset(0);
        issue(0, RT, 3'd0, 0, 3, 0, 3, tr);
        issue(0, LW, 3'd0, 0, 0, 5, 3, tr);
        do_reset(0);
        issue(0, LW, 3'd0, 0, 2, 3, 3, tr);
        // reset pulse in the middle of a stalled MEMWRITE
        op[0] = SW; f3[0] = 3'd2; zero[0] = 0;
        cyc(0, 4'd0, 1); cyc(0, 4'd1, 0); cyc(0, 4'd2, 0); cyc(0, 4'd5, 0);
        #2;
        chk("mem_write before reset", 32'(bus_a.mem_write), 32'd1);
        rst[0] = 1'b1;
        #1;
        chk("mem_write during reset", 32'(bus_a.mem_write), 32'd0);
        chk("mem_req during reset", 32'(bus_a.mem_req), 32'd0);
        chk("state during reset", 32'(st_a), 32'd0);
        do_reset(0);
        issue(0, RT, 3'd0, 0, 0, 0, 3, tr);
        random_run(0, 80);

        do_reset(1);
        // bne not supported: trap from DECODE
        issue(1, BR, 3'd1, 0, 0, 0, 20, tr);
        do_reset(1);
        issue(1, BR, 3'd0, 1, 0, 0, 3, tr);
        // no timeout: long read and fetch stalls just wait
        issue(1, LW, 3'd2, 0, 3, 3, 3, tr);
        issue(1, SW, 3'd2, 0, 7, 6, 3, tr);
        random_run(1, 40);

        @(posedge clk); @(negedge clk); #1;
        chk("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
